// File: rtl/ibex_pkg.sv
// Shared register-file constants and address-compare helpers for the write-side controller.
package ibex_pkg;

    localparam int unsigned RegAddrW = 5;

    // In RV32E only 16 registers exist, so address bit 4 takes no part in any compare.
    function automatic logic addr_eq(input logic [RegAddrW-1:0] a,
                                     input logic [RegAddrW-1:0] b,
                                     input logic                rv32e);
        if (rv32e) begin
            return a[3:0] == b[3:0];
        end
        return a == b;
    endfunction

    function automatic logic addr_nz(input logic [RegAddrW-1:0] a,
                                     input logic                rv32e);
        if (rv32e) begin
            return a[3:0] != 4'd0;
        end
        return a != '0;
    endfunction

endpackage

// File: rtl/ibex_rf_load_tracker.sv
// In-order FIFO of outstanding load destination registers, with per-entry match vectors
// for the write-after-write check and the read-port hazard checks.
module ibex_rf_load_tracker
    import ibex_pkg::*;
#(
    parameter bit          RV32E          = 1'b0,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 push_i,
    input  logic [RegAddrW-1:0]                  push_addr_i,
    input  logic                                 pop_i,
    input  logic [RegAddrW-1:0]                  q_a_i,
    input  logic [RegAddrW-1:0]                  q_b_i,
    input  logic [RegAddrW-1:0]                  q_w_i,
    output logic [RegAddrW-1:0]                  head_addr_o,
    output logic                                 full_o,
    output logic                                 empty_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]  count_o,
    output logic [MaxOutstanding-1:0]            match_a_o,
    output logic [MaxOutstanding-1:0]            match_b_o,
    output logic [MaxOutstanding-1:0]            match_w_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

    logic [RegAddrW-1:0]       r_addr [MaxOutstanding];
    logic [MaxOutstanding-1:0] r_valid;
    logic [PtrW-1:0]           r_wptr;
    logic [PtrW-1:0]           r_rptr;
    logic [CntW-1:0]           r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CntW'(MaxOutstanding));
    assign w_empty = (r_count == '0);
    assign w_pop   = pop_i && !w_empty;
    // A push into a full tracker is only legal when the head leaves in the same cycle.
    assign w_push  = push_i && (!w_full || w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < MaxOutstanding; i++) begin
                r_addr[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= (r_rptr == LastPtr) ? '0 : r_rptr + 1'b1;
            end
            // Placed after the pop so a full-FIFO push into the popped slot keeps it valid.
            if (w_push) begin
                r_valid[r_wptr] <= 1'b1;
                r_addr[r_wptr]  <= push_addr_i;
                r_wptr          <= (r_wptr == LastPtr) ? '0 : r_wptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_comb begin
        match_a_o = '0;
        match_b_o = '0;
        match_w_o = '0;
        for (int unsigned i = 0; i < MaxOutstanding; i++) begin
            match_a_o[i] = r_valid[i] && addr_eq(r_addr[i], q_a_i, RV32E);
            match_b_o[i] = r_valid[i] && addr_eq(r_addr[i], q_b_i, RV32E);
            match_w_o[i] = r_valid[i] && addr_eq(r_addr[i], q_w_i, RV32E);
        end
    end

    assign head_addr_o = r_addr[r_rptr];
    assign full_o      = w_full;
    assign empty_o     = w_empty;
    assign count_o     = r_count;

endmodule

// File: rtl/ibex_rf_write_ctrl.sv
// Regfile write-port arbiter: load responses take priority over ALU results, with WAW stalls
// against outstanding loads and read-after-write hazard flags for the ID stage.
module ibex_rf_write_ctrl
    import ibex_pkg::*;
#(
    parameter bit          RV32E          = 1'b0,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 alu_we_i,
    input  logic [RegAddrW-1:0]                  alu_waddr_i,
    input  logic [DataWidth-1:0]                 alu_wdata_i,
    output logic                                 alu_ready_o,
    input  logic                                 lsu_req_i,
    input  logic [RegAddrW-1:0]                  lsu_waddr_i,
    output logic                                 lsu_req_ready_o,
    input  logic                                 lsu_rvalid_i,
    input  logic [DataWidth-1:0]                 lsu_rdata_i,
    input  logic                                 lsu_err_i,
    input  logic [RegAddrW-1:0]                  raddr_a_i,
    input  logic [RegAddrW-1:0]                  raddr_b_i,
    output logic                                 hazard_a_o,
    output logic                                 hazard_b_o,
    output logic [RegAddrW-1:0]                  rf_waddr_o,
    output logic [DataWidth-1:0]                 rf_wdata_o,
    output logic                                 rf_we_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
    output logic                                 err_o
);

    logic [RegAddrW-1:0]       w_head_addr;
    logic                      w_full;
    logic                      w_empty;
    logic [MaxOutstanding-1:0] w_match_a;
    logic [MaxOutstanding-1:0] w_match_b;
    logic [MaxOutstanding-1:0] w_match_w;
    logic                      w_pop;
    logic                      w_load_wr;
    logic                      w_waw;
    logic                      w_alu_wr;

    logic                      r_we;
    logic [RegAddrW-1:0]       r_waddr;
    logic [DataWidth-1:0]      r_wdata;
    logic                      r_err;

    ibex_rf_load_tracker #(
        .RV32E          (RV32E),
        .MaxOutstanding (MaxOutstanding)
    ) u_tracker (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (lsu_req_i),
        .push_addr_i (lsu_waddr_i),
        .pop_i       (lsu_rvalid_i),
        .q_a_i       (raddr_a_i),
        .q_b_i       (raddr_b_i),
        .q_w_i       (alu_waddr_i),
        .head_addr_o (w_head_addr),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .count_o     (outstanding_o),
        .match_a_o   (w_match_a),
        .match_b_o   (w_match_b),
        .match_w_o   (w_match_w)
    );

    assign w_pop     = lsu_rvalid_i && !w_empty;
    assign w_load_wr = w_pop && !lsu_err_i && addr_nz(w_head_addr, RV32E);
    assign w_waw     = addr_nz(alu_waddr_i, RV32E) && (|w_match_w);

    assign alu_ready_o     = !alu_we_i || (!w_load_wr && !w_waw);
    assign w_alu_wr        = alu_we_i && alu_ready_o && addr_nz(alu_waddr_i, RV32E);
    assign lsu_req_ready_o = !w_full || lsu_rvalid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_we  <= w_load_wr || w_alu_wr;
            r_err <= lsu_rvalid_i && w_empty;
            if (w_load_wr) begin
                r_waddr <= w_head_addr;
                r_wdata <= lsu_rdata_i;
            end else if (w_alu_wr) begin
                r_waddr <= alu_waddr_i;
                r_wdata <= alu_wdata_i;
            end
        end
    end

    // Hazards look only at registered state, keeping lsu_rvalid_i off the ID-stage timing path.
    assign hazard_a_o = addr_nz(raddr_a_i, RV32E) &&
                        ((|w_match_a) || (r_we && addr_eq(r_waddr, raddr_a_i, RV32E)));
    assign hazard_b_o = addr_nz(raddr_b_i, RV32E) &&
                        ((|w_match_b) || (r_we && addr_eq(r_waddr, raddr_b_i, RV32E)));

    assign rf_we_o    = r_we;
    assign rf_waddr_o = r_waddr;
    assign rf_wdata_o = r_wdata;
    assign err_o      = r_err;

    a_no_req_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lsu_req_i |-> lsu_req_ready_o);

endmodule

// File: tb/tb_ibex_rf_write_ctrl.sv
// Directed bench for ibex_rf_write_ctrl; a second instance with RV32E=1 checks masked compares.
module tb_ibex_rf_write_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_we;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        alu_ready;
    logic        lsu_req;
    logic [4:0]  lsu_waddr;
    logic        lsu_req_ready;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic        hazard_a;
    logic        hazard_b;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_we;
    logic [1:0]  outstanding;
    logic        err;

    logic [4:0]  e_raddr_a;
    logic        e_alu_ready;
    logic        e_lsu_req_ready;
    logic        e_hazard_a;
    logic        e_hazard_b;
    logic [4:0]  e_rf_waddr;
    logic [31:0] e_rf_wdata;
    logic        e_rf_we;
    logic [1:0]  e_outstanding;
    logic        e_err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    ibex_rf_write_ctrl #(
        .RV32E          (1'b0),
        .DataWidth      (32),
        .MaxOutstanding (2)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .alu_we_i        (alu_we),
        .alu_waddr_i     (alu_waddr),
        .alu_wdata_i     (alu_wdata),
        .alu_ready_o     (alu_ready),
        .lsu_req_i       (lsu_req),
        .lsu_waddr_i     (lsu_waddr),
        .lsu_req_ready_o (lsu_req_ready),
        .lsu_rvalid_i    (lsu_rvalid),
        .lsu_rdata_i     (lsu_rdata),
        .lsu_err_i       (lsu_err),
        .raddr_a_i       (raddr_a),
        .raddr_b_i       (raddr_b),
        .hazard_a_o      (hazard_a),
        .hazard_b_o      (hazard_b),
        .rf_waddr_o      (rf_waddr),
        .rf_wdata_o      (rf_wdata),
        .rf_we_o         (rf_we),
        .outstanding_o   (outstanding),
        .err_o           (err)
    );

    ibex_rf_write_ctrl #(
        .RV32E          (1'b1),
        .DataWidth      (32),
        .MaxOutstanding (2)
    ) dut_e (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .alu_we_i        (alu_we),
        .alu_waddr_i     (alu_waddr),
        .alu_wdata_i     (alu_wdata),
        .alu_ready_o     (e_alu_ready),
        .lsu_req_i       (lsu_req),
        .lsu_waddr_i     (lsu_waddr),
        .lsu_req_ready_o (e_lsu_req_ready),
        .lsu_rvalid_i    (lsu_rvalid),
        .lsu_rdata_i     (lsu_rdata),
        .lsu_err_i       (lsu_err),
        .raddr_a_i       (e_raddr_a),
        .raddr_b_i       (raddr_b),
        .hazard_a_o      (e_hazard_a),
        .hazard_b_o      (e_hazard_b),
        .rf_waddr_o      (e_rf_waddr),
        .rf_wdata_o      (e_rf_wdata),
        .rf_we_o         (e_rf_we),
        .outstanding_o   (e_outstanding),
        .err_o           (e_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge, where inputs change and registers are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        alu_we     = 1'b0;
        alu_waddr  = '0;
        alu_wdata  = '0;
        lsu_req    = 1'b0;
        lsu_waddr  = '0;
        lsu_rvalid = 1'b0;
        lsu_rdata  = '0;
        lsu_err    = 1'b0;
        raddr_a    = '0;
        raddr_b    = '0;
        e_raddr_a  = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        check("rst_we",        32'(rf_we), 32'd0);
        check("rst_waddr",     32'(rf_waddr), 32'd0);
        check("rst_wdata",     rf_wdata, 32'd0);
        check("rst_out",       32'(outstanding), 32'd0);
        check("rst_err",       32'(err), 32'd0);
        check("rst_req_ready", 32'(lsu_req_ready), 32'd1);
        check("rst_alu_ready", 32'(alu_ready), 32'd1);
        check("rst_hz_a",      32'(hazard_a), 32'd0);

        // ALU write x5
        alu_we = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'hDEADBEEF;
        #1 check("alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_we = 1'b0; raddr_a = 5'd5;
        check("alu_we",    32'(rf_we), 32'd1);
        check("alu_waddr", 32'(rf_waddr), 32'd5);
        check("alu_wdata", rf_wdata, 32'hDEADBEEF);
        #1 check("hz_a_wr", 32'(hazard_a), 32'd1);
        tick();
        raddr_a = 5'd0;
        check("alu_we_1cyc", 32'(rf_we), 32'd0);

        // Load x7 then simultaneous response and ALU x3
        lsu_req = 1'b1; lsu_waddr = 5'd7;
        tick();
        lsu_req = 1'b0;
        check("ld7_out", 32'(outstanding), 32'd1);
        alu_we = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'h0000AAAA;
        lsu_rvalid = 1'b1; lsu_rdata = 32'h1234;
        #1 check("prio_alu_stall", 32'(alu_ready), 32'd0);
        tick();
        lsu_rvalid = 1'b0;
        check("prio_ld_we",    32'(rf_we), 32'd1);
        check("prio_ld_waddr", 32'(rf_waddr), 32'd7);
        check("prio_ld_wdata", rf_wdata, 32'h1234);
        check("prio_out",      32'(outstanding), 32'd0);
        #1 check("prio_alu_go", 32'(alu_ready), 32'd1);
        tick();
        alu_we = 1'b0;
        check("prio_alu_we",    32'(rf_we), 32'd1);
        check("prio_alu_waddr", 32'(rf_waddr), 32'd3);
        check("prio_alu_wdata", rf_wdata, 32'h0000AAAA);
        tick();

        // Fill tracker with x4, x4
        lsu_req = 1'b1; lsu_waddr = 5'd4;
        tick();
        tick();
        lsu_req = 1'b0;
        check("full_out", 32'(outstanding), 32'd2);
        #1 check("full_not_ready", 32'(lsu_req_ready), 32'd0);
        lsu_req = 1'b1; lsu_rvalid = 1'b1; lsu_rdata = 32'h55;
        #1 check("full_ready_pop", 32'(lsu_req_ready), 32'd1);
        tick();
        lsu_req = 1'b0; lsu_rvalid = 1'b0;
        check("pushpop_out",   32'(outstanding), 32'd2);
        check("pushpop_waddr", 32'(rf_waddr), 32'd4);
        check("pushpop_wdata", rf_wdata, 32'h55);
        lsu_rvalid = 1'b1; lsu_rdata = 32'h66;
        tick();
        lsu_rdata = 32'h77;
        tick();
        lsu_rvalid = 1'b0;
        check("drain_out",   32'(outstanding), 32'd0);
        check("drain_wdata", rf_wdata, 32'h77);
        tick();

        // Spurious response, then bus-error response
        lsu_rvalid = 1'b1; lsu_rdata = 32'h99;
        tick();
        lsu_rvalid = 1'b0;
        check("spur_err", 32'(err), 32'd1);
        check("spur_we",  32'(rf_we), 32'd0);
        check("spur_out", 32'(outstanding), 32'd0);
        tick();
        check("spur_err_1cyc", 32'(err), 32'd0);
        lsu_req = 1'b1; lsu_waddr = 5'd9;
        tick();
        lsu_req = 1'b0;
        lsu_rvalid = 1'b1; lsu_err = 1'b1; lsu_rdata = 32'hBAD;
        tick();
        lsu_rvalid = 1'b0; lsu_err = 1'b0;
        check("buserr_we",  32'(rf_we), 32'd0);
        check("buserr_err", 32'(err), 32'd0);
        check("buserr_out", 32'(outstanding), 32'd0);
        tick();

        // Hazards and WAW against pending x6
        lsu_req = 1'b1; lsu_waddr = 5'd6;
        tick();
        lsu_req = 1'b0;
        raddr_a = 5'd6; raddr_b = 5'd22; e_raddr_a = 5'd22;
        alu_we = 1'b1; alu_waddr = 5'd6; alu_wdata = 32'hC0DE;
        #1;
        check("hz_a_ld",    32'(hazard_a), 32'd1);
        check("hz_b_22",    32'(hazard_b), 32'd0);
        check("hz_e_22",    32'(e_hazard_a), 32'd1);
        check("waw_stall",  32'(alu_ready), 32'd0);
        raddr_a = 5'd0;
        #1 check("hz_a_x0", 32'(hazard_a), 32'd0);
        tick();
        check("waw_held", 32'(alu_ready), 32'd0);
        lsu_rvalid = 1'b1; lsu_rdata = 32'h600;
        tick();
        lsu_rvalid = 1'b0;
        check("waw_ld_waddr", 32'(rf_waddr), 32'd6);
        check("waw_ld_wdata", rf_wdata, 32'h600);
        #1 check("waw_release", 32'(alu_ready), 32'd1);
        tick();
        alu_we = 1'b0; raddr_b = 5'd0; e_raddr_a = 5'd0;
        check("waw_alu_wdata", rf_wdata, 32'hC0DE);
        tick();

        // ALU to x0 accepted without a write; reset drops in-flight loads
        alu_we = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'h1;
        #1 check("x0_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_we = 1'b0;
        check("x0_no_we", 32'(rf_we), 32'd0);
        lsu_req = 1'b1; lsu_waddr = 5'd2;
        tick();
        lsu_req = 1'b0;
        check("pre_rst_out", 32'(outstanding), 32'd1);
        rst_n = 1'b0;
        #1 check("midrst_out", 32'(outstanding), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule
